// File: rtl/intp_pkg.sv
// intp_pkg: shared types and constants for the interrupt controller
package intp_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_SERV = 2'd2} state_t;
  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_MODE    = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;
  localparam logic [2:0] ID_FORCED = 3'd4;
  function automatic logic [2:0] pick(input logic [4:0] e);
    logic [2:0] r;
    r = ID_FORCED;
    if (!e[4])
      for (int i = 3; i >= 0; i--)
        if (e[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/intp_sync.sv
// intp_sync: 2-flop synchronizer, history flop and registered rising-edge pulse
module intp_sync
  import intp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);
  logic s1, s2, h;
  logic [1:0] age;
  assign lvl = h;
  // age gates the edge pulse until the chain holds post-reset samples only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      h <= 1'b0;
      age <= 2'd0;
      rise <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      h <= s2;
      age <= age + {1'b0, ~&age};
      rise <= &age & s2 & ~h;
    end
  end
endmodule

// File: rtl/intp_ctrl.sv
// intp_ctrl: prioritised interrupt controller with edge/level sources and a forced source
module intp_ctrl
  import intp_pkg::*;
#(
  parameter int DW = 16,
  parameter int NEXT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NEXT-1:0] intp_ext,
  input  logic            intp_s,
  input  logic            reg_we,
  input  logic [1:0]      reg_addr,
  input  logic [DW-1:0]   reg_wdata,
  output logic [DW-1:0]   reg_rdata,
  input  logic            irq_ack,
  input  logic            irq_ret,
  output logic            irq_req,
  output logic [2:0]      irq_id
);
  logic [NEXT-1:0] lvl, rise, mode;
  logic [4:0] en, pend, pend_nx, elig, set, edge_m, lv, clr;
  logic s_h, armed;
  logic unused;
  state_t state;
  assign unused = ^reg_wdata[DW-1:5];
  for (genvar i = 0; i < NEXT; i++) begin : g_sync
    intp_sync u_sync (.clk(clk), .rst(rst), .d(intp_ext[i]), .lvl(lvl[i]), .rise(rise[i]));
  end
  // unused source slots behave as edge-mode bits that are never set, so they stay 0
  always_comb begin
    set = '0;
    edge_m = '1;
    lv = '0;
    set[NEXT-1:0] = rise;
    set[4] = intp_s & ~s_h & armed;
    edge_m[NEXT-1:0] = mode;
    lv[NEXT-1:0] = lvl;
    clr = ((reg_we && reg_addr == A_PENDING) ? reg_wdata[4:0] : 5'd0) |
          ((state == S_REQ && irq_ack) ? 5'd1 << irq_id : 5'd0);
    pend_nx = (edge_m & (set | (pend & ~clr))) | (~edge_m & lv);
    elig = pend & {1'b1, en[3:0] & {4{en[4]}}};
    reg_rdata = reg_addr == A_ENABLE  ? DW'(en) :
                reg_addr == A_PENDING ? DW'(pend) :
                reg_addr == A_MODE    ? DW'(mode) : DW'({state, irq_id});
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      en <= '0;
      mode <= '0;
      s_h <= 1'b0;
      armed <= 1'b0;
    end else begin
      pend <= pend_nx;
      s_h <= intp_s;
      armed <= 1'b1;
      if (reg_we && reg_addr == A_ENABLE) en <= reg_wdata[4:0];
      if (reg_we && reg_addr == A_MODE) mode <= reg_wdata[NEXT-1:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      irq_req <= 1'b0;
      irq_id <= 3'd0;
    end else begin
      case (state)
        S_IDLE: if (|elig) begin
          state <= S_REQ;
          irq_req <= 1'b1;
          irq_id <= pick(elig);
        end
        S_REQ: if (irq_ack) begin
          state <= S_SERV;
          irq_req <= 1'b0;
        end
        S_SERV: if (irq_ret) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intp_ctrl.sv
// tb_intp_ctrl: table-driven and directed checks of intp_ctrl
module tb_intp_ctrl;
  logic clk = 0, rst = 1;
  logic [3:0] intp_ext = '0;
  logic intp_s = 0, reg_we = 0, irq_ack = 0, irq_ret = 0;
  logic [1:0] reg_addr = '0;
  logic [15:0] reg_wdata = '0;
  logic [15:0] reg_rdata;
  logic irq_req;
  logic [2:0] irq_id;
  int nvec = 0, nerr = 0;

  intp_ctrl #(.DW(16), .NEXT(4)) dut (
    .clk(clk), .rst(rst), .intp_ext(intp_ext), .intp_s(intp_s),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .irq_ack(irq_ack), .irq_ret(irq_ret), .irq_req(irq_req), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [1:0] addr; logic [15:0] wdata; logic [3:0] ext;
    logic ack; logic ret; logic [1:0] rd; logic req; logic [2:0] id; logic [15:0] rdv;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    reg_we = 1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string name);
    reg_addr = a;
    #1;
    chk(name, reg_rdata, exp);
  endtask

  task automatic ack_p();
    irq_ack = 1; tick(); irq_ack = 0;
  endtask

  task automatic ret_p();
    irq_ret = 1; tick(); irq_ret = 0;
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!irq_req && k < 12) begin tick(); k++; end
    chk(name, {15'd0, irq_req}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 2'd0, 16'h0011, 4'h0, 0, 0, 2'd0, 0, 3'd0, 16'h0011};
    tbl[1]  = '{1, 2'd2, 16'h0001, 4'h0, 0, 0, 2'd2, 0, 3'd0, 16'h0001};
    tbl[2]  = '{0, 2'd0, 16'h0000, 4'h1, 0, 0, 2'd1, 0, 3'd0, 16'h0000};
    tbl[3]  = '{0, 2'd0, 16'h0000, 4'h1, 0, 0, 2'd1, 0, 3'd0, 16'h0000};
    tbl[4]  = '{0, 2'd0, 16'h0000, 4'h1, 0, 0, 2'd1, 0, 3'd0, 16'h0000};
    tbl[5]  = '{0, 2'd0, 16'h0000, 4'h1, 0, 0, 2'd1, 0, 3'd0, 16'h0001};
    tbl[6]  = '{0, 2'd0, 16'h0000, 4'h1, 0, 0, 2'd3, 1, 3'd0, 16'h0008};
    tbl[7]  = '{0, 2'd0, 16'h0000, 4'h1, 0, 1, 2'd3, 1, 3'd0, 16'h0008};
    tbl[8]  = '{0, 2'd0, 16'h0000, 4'h1, 1, 0, 2'd1, 0, 3'd0, 16'h0000};
    tbl[9]  = '{0, 2'd0, 16'h0000, 4'h1, 1, 0, 2'd3, 0, 3'd0, 16'h0010};
    tbl[10] = '{0, 2'd0, 16'h0000, 4'h1, 0, 1, 2'd3, 0, 3'd0, 16'h0000};
    tbl[11] = '{0, 2'd0, 16'h0000, 4'h0, 0, 0, 2'd1, 0, 3'd0, 16'h0000};

    tick(3);
    rst = 0;
    tick(5);
    chk("rst_req", {15'd0, irq_req}, 16'd0);
    chk("rst_id", {13'd0, irq_id}, 16'd0);
    rd(2'd0, 16'h0000, "rst_enable");
    rd(2'd1, 16'h0000, "rst_pending");
    rd(2'd2, 16'h0000, "rst_mode");
    rd(2'd3, 16'h0000, "rst_status");

    for (int i = 0; i < 12; i++) begin
      reg_we = tbl[i].we; reg_addr = tbl[i].addr; reg_wdata = tbl[i].wdata;
      intp_ext = tbl[i].ext; irq_ack = tbl[i].ack; irq_ret = tbl[i].ret;
      tick();
      reg_we = 0; irq_ack = 0; irq_ret = 0; reg_addr = tbl[i].rd;
      #1;
      chk($sformatf("v%0d_req", i), {15'd0, irq_req}, {15'd0, tbl[i].req});
      chk($sformatf("v%0d_id", i), {13'd0, irq_id}, {13'd0, tbl[i].id});
      chk($sformatf("v%0d_rd", i), reg_rdata, tbl[i].rdv);
    end

    wr(2'd0, 16'h001F);
    wr(2'd2, 16'h000F);
    intp_ext = 4'b1010;
    wait_req("prio_req1");
    chk("prio_id1", {13'd0, irq_id}, 16'd1);
    ack_p();
    ret_p();
    chk("prio_idle", {15'd0, irq_req}, 16'd0);
    tick();
    chk("prio_req3", {15'd0, irq_req}, 16'd1);
    chk("prio_id3", {13'd0, irq_id}, 16'd3);
    ack_p();
    ret_p();
    rd(2'd1, 16'h0000, "prio_pend");
    intp_ext = 4'b0000;

    wr(2'd0, 16'h0000);
    intp_s = 1;
    tick();
    intp_s = 0;
    tick();
    chk("forced_req", {15'd0, irq_req}, 16'd1);
    chk("forced_id", {13'd0, irq_id}, 16'd4);
    rd(2'd3, 16'h000C, "forced_status");
    ack_p();
    ret_p();

    wr(2'd0, 16'h0015);
    wr(2'd2, 16'h0005);
    intp_ext = 4'b0001;
    wait_req("nest_req0");
    chk("nest_id0", {13'd0, irq_id}, 16'd0);
    ack_p();
    intp_ext = 4'b0101;
    tick(6);
    chk("nest_noreq", {15'd0, irq_req}, 16'd0);
    rd(2'd1, 16'h0004, "nest_pend");
    ret_p();
    chk("nest_ret_idle", {15'd0, irq_req}, 16'd0);
    tick();
    chk("nest_req2", {15'd0, irq_req}, 16'd1);
    chk("nest_id2", {13'd0, irq_id}, 16'd2);
    ack_p();
    ret_p();
    intp_ext = 4'b0000;
    tick(4);

    wr(2'd2, 16'h0000);
    wr(2'd0, 16'h0012);
    intp_ext = 4'b0010;
    wait_req("lvl_req");
    chk("lvl_id", {13'd0, irq_id}, 16'd1);
    ack_p();
    rd(2'd1, 16'h0002, "lvl_pend_ack");
    ret_p();
    tick();
    chk("lvl_rereq", {15'd0, irq_req}, 16'd1);
    wr(2'd1, 16'h0002);
    rd(2'd1, 16'h0002, "lvl_pend_wr");
    wr(2'd0, 16'h0000);
    chk("lvl_hold_req", {15'd0, irq_req}, 16'd1);
    ack_p();
    intp_ext = 4'b0000;
    ret_p();
    tick(5);
    rd(2'd1, 16'h0000, "lvl_pend_drop");
    chk("lvl_noreq", {15'd0, irq_req}, 16'd0);

    wr(2'd2, 16'h0001);
    wr(2'd0, 16'h0011);
    intp_ext = 4'b0001;
    wait_req("rst_mid_req");
    #2 rst = 1;
    #1 chk("rst_async_drop", {15'd0, irq_req}, 16'd0);
    intp_ext = 4'b0000;
    tick(2);
    #2 rst = 0;
    tick(3);
    rd(2'd1, 16'h0000, "rst_rel_pend");
    rd(2'd0, 16'h0000, "rst_rel_enable");
    tick(8);
    chk("rst_rel_noreq", {15'd0, irq_req}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
